// File: rtl/trap_redirect_ctrl_pkg.sv
// Shared types for the writeback trap/redirect controller: exception cause,
// controller state encoding and the mcause interrupt-flag position.
package trap_redirect_ctrl_pkg;

    typedef logic [3:0] ecause_t;

    localparam ecause_t ECAUSE_INSN_MISALIGNED = 4'd0;
    localparam ecause_t ECAUSE_ILLEGAL_INSN    = 4'd2;
    localparam ecause_t ECAUSE_ECALL_M         = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } ctrl_state_t;

    localparam int MCAUSE_IRQ_BIT = 31;

    function automatic logic [31:0] mk_mcause(input logic is_irq, input logic [3:0] cause);
        logic [31:0] v;
        v                 = '0;
        v[MCAUSE_IRQ_BIT] = is_irq;
        v[3:0]            = cause;
        return v;
    endfunction

endpackage

// File: rtl/trap_redirect_ctrl.sv
// Writeback trap/flush/interrupt sequencer: holds writeback while the bus drains,
// strobes trap state into the CSR file, then hands one redirect to fetch1.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | watching writeback for exc > flush > irq
// DRAIN    | event latched, waiting for fetch1/memory1 fills to finish
// COMMIT   | one cycle: csr_trap_we pulse (trap events only)
// REDIRECT | redir_valid held with stable redir_pc until fe1_redir_ack
module trap_redirect_ctrl
    import trap_redirect_ctrl_pkg::*;
#(
    parameter bit VECTORED  = 1'b0,
    parameter int DRAIN_MAX = 64
) (
    input  logic        clk_core_i,
    input  logic        reset_i,
    input  logic        wb_valid_i,
    input  logic        wb_exc_i,
    input  ecause_t     wb_exc_cause_i,
    input  logic        wb_flush_i,
    input  logic [29:0] wb_pc_i,
    input  logic        fe1_busy_i,
    input  logic        mem1_busy_i,
    input  logic        irq_pending_i,
    input  logic [3:0]  irq_cause_i,
    input  logic [29:0] csr_mtvec_i,
    input  logic        fe1_redir_ack_i,
    output logic        ctrl_hold_o,
    output logic        ctrl_kill_o,
    output logic        csr_trap_we_o,
    output logic [29:0] csr_mepc_o,
    output logic [31:0] csr_mcause_o,
    output logic        redir_valid_o,
    output logic [29:0] redir_pc_o,
    output logic        ctrl_drain_err_o
);

    localparam logic [7:0] DRAIN_MAX_C = 8'(DRAIN_MAX);

    ctrl_state_t state_q;
    logic        kill_q;
    logic        trap_we_q;
    logic        redir_valid_q;
    logic        drain_err_q;
    logic [7:0]  drain_cnt_q;
    logic [29:0] mepc_q;
    logic [31:0] mcause_q;
    logic [29:0] redir_pc_q;
    logic [29:0] target_q;
    logic        is_trap_q;

    logic        busy;
    logic        ev_exc;
    logic        ev_flush;
    logic        ev_irq;
    logic        ev_any;
    logic [29:0] target_d;
    logic [29:0] mepc_d;
    logic [31:0] mcause_d;
    logic [7:0]  drain_cnt_d;

    assign busy     = fe1_busy_i | mem1_busy_i;
    assign ev_exc   = wb_exc_i;
    assign ev_flush = ~wb_exc_i & wb_valid_i & wb_flush_i;
    assign ev_irq   = irq_pending_i & wb_valid_i & ~wb_flush_i & ~wb_exc_i;
    assign ev_any   = ev_exc | ev_flush | ev_irq;

    always_comb begin
        target_d = csr_mtvec_i;
        if (ev_flush) begin
            target_d = wb_pc_i + 30'd1;
        end else if (ev_irq && VECTORED) begin
            target_d = csr_mtvec_i + {26'b0, irq_cause_i};
        end
        // Interrupts are taken after the instruction retires, so mepc skips it.
        mepc_d      = ev_exc ? wb_pc_i : wb_pc_i + 30'd1;
        mcause_d    = mk_mcause(~ev_exc, ev_exc ? wb_exc_cause_i : irq_cause_i);
        drain_cnt_d = (drain_cnt_q == 8'hFF) ? drain_cnt_q : drain_cnt_q + 8'd1;
    end

    assign ctrl_hold_o = (state_q != ST_IDLE) |
                         ((wb_exc_i | (wb_valid_i & wb_flush_i)) & busy);

    always_ff @(posedge clk_core_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            kill_q        <= 1'b0;
            trap_we_q     <= 1'b0;
            redir_valid_q <= 1'b0;
            drain_err_q   <= 1'b0;
            drain_cnt_q   <= 8'd0;
            mepc_q        <= 30'd0;
            mcause_q      <= 32'd0;
            redir_pc_q    <= 30'd0;
            target_q      <= 30'd0;
            is_trap_q     <= 1'b0;
        end else begin
            trap_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ev_any) begin
                        kill_q      <= 1'b1;
                        target_q    <= target_d;
                        is_trap_q   <= ~ev_flush;
                        drain_cnt_q <= 8'd0;
                        if (!ev_flush) begin
                            mepc_q   <= mepc_d;
                            mcause_q <= mcause_d;
                        end
                        if (busy) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            state_q   <= ST_COMMIT;
                            trap_we_q <= ~ev_flush;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!busy) begin
                        state_q     <= ST_COMMIT;
                        drain_cnt_q <= 8'd0;
                        trap_we_q   <= is_trap_q;
                    end else begin
                        drain_cnt_q <= drain_cnt_d;
                        if (drain_cnt_d >= DRAIN_MAX_C) begin
                            drain_err_q <= 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    redir_valid_q <= 1'b1;
                    redir_pc_q    <= target_q;
                    state_q       <= ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    if (fe1_redir_ack_i) begin
                        redir_valid_q <= 1'b0;
                        kill_q        <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ctrl_kill_o      = kill_q;
    assign csr_trap_we_o    = trap_we_q;
    assign csr_mepc_o       = mepc_q;
    assign csr_mcause_o     = mcause_q;
    assign redir_valid_o    = redir_valid_q;
    assign redir_pc_o       = redir_pc_q;
    assign ctrl_drain_err_o = drain_err_q;

endmodule

// File: doc/trap_redirect_ctrl.md
Name: trap_redirect_ctrl

Overview:
- Sequences the pipeline response to events leaving the writeback stage: exceptions, flush-type retirements (e.g. fence.i, CSR side effects) and pending interrupts.
- Holds writeback while fetch1/memory1 bus transactions drain, then:
  - commits trap state to the CSR file, and
  - issues a single redirect to fetch with a valid/ack handshake.
- Sits between stage_write, the CSR block and stage_fetch1.
- Replaces the local writeback stall equation with a controller-driven hold.

Parameters:
- VECTORED, 0, 1 = interrupt redirect target is mtvec + irq_cause words; exceptions always go to mtvec base.
- DRAIN_MAX, 64, drain cycles allowed before ctrl_drain_err sets (8-bit counter, saturating).

Ports:
- clk_core  in  1  core clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- wb_valid  in  1  writeback holds a retiring instruction.
- wb_exc  in  1  writeback holds an exception.
- wb_exc_cause  in  ecause_t  exception cause.
- wb_flush  in  1  retiring instruction requires a refetch of pc+4.
- wb_pc  in  30  [31:2] pc of the writeback instruction.
- fe1_busy  in  1  fetch1 cache fill/evict in progress.
- mem1_busy  in  1  memory1 cache fill/evict in progress.
- irq_pending  in  1  enabled interrupt pending (already masked by mstatus.MIE).
- irq_cause  in  4  interrupt cause code.
- csr_mtvec  in  30  [31:2] trap vector base.
- fe1_redir_ack  in  1  fetch1 accepted the redirect this cycle.
- ctrl_hold  out  1  freeze writeback (replaces wb_stall).
- ctrl_kill  out  1  kill all younger in-flight instructions.
- csr_trap_we  out  1  one-cycle strobe: write mepc/mcause, update mstatus.
- csr_mepc  out  30  [31:2] value for mepc.
- csr_mcause  out  32  {is_irq, 27'b0, cause[3:0]}.
- redir_valid  out  1  redirect request to fetch1.
- redir_pc  out  30  [31:2] redirect target.
- ctrl_drain_err  out  1  sticky; drain exceeded DRAIN_MAX.

Behaviour:
- Reset (takes effect in any state, including mid-drain or mid-redirect):
  - state = IDLE.
  - ctrl_hold, ctrl_kill, csr_trap_we, redir_valid, ctrl_drain_err, drain counter = 0.
  - csr_mepc, csr_mcause, redir_pc = 0.
- All outputs are registered except ctrl_hold, which is combinational from state and inputs.
- States: IDLE, DRAIN, COMMIT, REDIRECT.
- IDLE event selection, evaluated each cycle, priority exc > flush > irq:
  - exc: wb_exc. Latch mepc = wb_pc, cause = wb_exc_cause, is_irq = 0, target = csr_mtvec.
  - flush: wb_valid & wb_flush. Latch target = wb_pc + 1 (30-bit wrap). No CSR write.
  - irq: irq_pending & wb_valid & ~wb_flush & ~wb_exc. Interrupt is taken after the instruction retires. Latch mepc = wb_pc + 1, cause = irq_cause, is_irq = 1, target = csr_mtvec (+ irq_cause if VECTORED).
  - On any event: ctrl_kill = 1 from the next cycle until the redirect is acked. Next state = DRAIN if fe1_busy | mem1_busy, else COMMIT.
- ctrl_hold:
  - In IDLE: (wb_exc | wb_valid & wb_flush) & (fe1_busy | mem1_busy).
  - Held 1 in DRAIN, COMMIT and REDIRECT.
- DRAIN:
  - Counter increments, saturating at 255.
  - If counter reaches DRAIN_MAX, ctrl_drain_err sets; it is sticky until reset and does not abort the drain.
  - When both busy signals are 0, go to COMMIT and clear the counter.
- COMMIT (1 cycle):
  - csr_trap_we = 1 for exc/irq events, 0 for flush.
  - redir_valid rises, redir_pc = target. Go to REDIRECT.
- REDIRECT:
  - redir_valid and redir_pc are held stable until fe1_redir_ack.
  - On the ack cycle: return to IDLE; redir_valid and ctrl_kill drop next cycle.
  - The ack may arrive in the first REDIRECT cycle, giving minimum event-to-IDLE latency of 3 cycles without drain.
- New events seen while not in IDLE are ignored; the killed pipeline cannot produce them legitimately.
- irq_pending deasserting after latch does not cancel the trap.

Decomposition:
- Add ctrl_state_t (IDLE/DRAIN/COMMIT/REDIRECT) and the mcause is_irq bit-position constant to defines.svh alongside ecause_t.
- No sub-module; the drain counter is inline.

Test Plan:
- Exception, no busy: wb_exc=1, cause=2 (illegal), wb_pc=0x100>>2, mtvec=0x800>>2 → csr_trap_we pulse with mepc=0x100, mcause=0x00000002; redir_pc=0x800 held until ack; back in IDLE 3 cycles after the event with immediate ack.
- Exception during fill: wb_exc with mem1_busy=1 for 10 cycles → ctrl_hold=1 and ctrl_kill=1 throughout; csr_trap_we exactly once, 1 cycle after mem1_busy falls.
- Flush: wb_valid=wb_flush=1, wb_pc=0x2000>>2 → no csr_trap_we; redir_pc=0x2004; wb_pc=0xFFFFFFFC wraps to 0.
- Vectored interrupt (VECTORED=1): irq_pending=1, irq_cause=7, wb_valid=1, wb_pc=0x40 → mepc=0x44, mcause=0x80000007, redir_pc=mtvec+0x1C.
- Priority and ack stall: wb_exc=1 with irq_pending=1 → exception taken, mcause bit31=0; ack delayed 5 cycles → redir_pc stable, redir_valid=1 throughout.
- Drain timeout and reset: fe1_busy stuck high with DRAIN_MAX=4 → ctrl_drain_err=1 after 4 drain cycles; reset asserted mid-DRAIN → all outputs 0, state IDLE next cycle.
